uart_frame_sender: RTL and testbench



---
 rtl/uart_frame_sender.sv | 113 +++++++++++
 tb/tb_uart_frame_sender.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_sender.sv
// uart_frame_sender
//   Takes a wide frame on a one-cycle send request and writes it byte by
//   byte into a UART transmit FIFO, stalling whenever that FIFO is full.
//   Byte 0 (sendData[7:0]) goes first, byte NBYTES-1 last.
//
// Parameters
//   NBYTES : bytes per frame (frame width NBYTES*8)
//   CNT_W  : byte counter width, 2**CNT_W must exceed NBYTES
//
// Ports
//   clock      : system clock, rising edge
//   reset      : synchronous active-high reset
//   sendSignal : send request, only looked at while idle
//   sendData   : frame payload, captured in full on an accepted request
//   tx_full    : TX FIFO full flag, no write is issued while high
//   wr_uart    : FIFO write strobe, one byte per high cycle
//   w_data     : byte presented to the FIFO
//   busy       : a frame is in flight
//   done       : one-cycle pulse after the last byte has been written
module uart_frame_sender #(
  parameter int NBYTES = 220,
  parameter int CNT_W  = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  sendSignal,
  input  logic [NBYTES*8-1:0]   sendData,
  input  logic                  tx_full,
  output logic                  wr_uart,
  output logic [7:0]            w_data,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NBYTES - 1);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [NBYTES*8-1:0] frame_q, frame_d;
  logic                done_q, done_d;

  // Byte view of the captured frame so the counter selects a whole byte.
  logic [7:0] frame_bytes [NBYTES];

  genvar gi;
  generate
    for (gi = 0; gi < NBYTES; gi++) begin : g_bytes
      assign frame_bytes[gi] = frame_q[8*gi +: 8];
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    frame_d = frame_q;
    done_d  = 1'b0;
    wr_uart = 1'b0;

    case (state_q)
      IDLE: begin
        if (sendSignal) begin
          frame_d = sendData;
          cnt_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        // A stalled cycle leaves counter and byte untouched, so nothing is
        // lost or repeated across a full period.
        if (!tx_full) begin
          wr_uart = 1'b1;
          if (cnt_q == LAST_IDX) begin
            cnt_d   = '0;
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // An abort must not push one more byte into the FIFO on the reset edge.
    if (reset) begin
      wr_uart = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      frame_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      frame_q <= frame_d;
      done_q  <= done_d;
    end
  end

  assign w_data = frame_bytes[cnt_q];
  assign busy   = (state_q == SEND);
  assign done   = done_q;

endmodule

// File: tb/tb_uart_frame_sender.sv
// tb_uart_frame_sender
//   Two instances: the default 220-byte build (a) and a 4-byte build (b).
//   The stimulus pushes expected bytes and expected done cycles into queues;
//   a monitor pops and compares whenever a write strobe or done pulse shows.
module tb_uart_frame_sender;

  localparam int NB_A = 220;
  localparam int NB_B = 4;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic              reset;
  logic              sig_a, sig_b, full_a, full_b;
  logic [NB_A*8-1:0] data_a;
  logic [NB_B*8-1:0] data_b;
  logic              wr_a, wr_b, busy_a, busy_b, done_a, done_b;
  logic [7:0]        wd_a, wd_b;

  uart_frame_sender #(.NBYTES(NB_A), .CNT_W(8)) dut_a (
    .clock(clock), .reset(reset), .sendSignal(sig_a), .sendData(data_a),
    .tx_full(full_a), .wr_uart(wr_a), .w_data(wd_a), .busy(busy_a), .done(done_a)
  );

  uart_frame_sender #(.NBYTES(NB_B), .CNT_W(3)) dut_b (
    .clock(clock), .reset(reset), .sendSignal(sig_b), .sendData(data_b),
    .tx_full(full_b), .wr_uart(wr_b), .w_data(wd_b), .busy(busy_b), .done(done_b)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [7:0] qa[$];
  logic [7:0] qb[$];
  int         da[$];
  int         db[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Edge counter: the interval after edge N carries label N.
  initial forever begin
    @(posedge clock);
    cyc++;
  end

  // Monitor
  initial forever begin
    logic [7:0] eb;
    int         ec;
    @(negedge clock);
    if (wr_a === 1'b1) begin
      if (qa.size() == 0) begin
        total++; bad++;
        $display("FAIL a_extra_write: got write of %02h, required no write (cycle %0d)", wd_a, cyc);
      end else begin
        eb = qa.pop_front();
        chk("a_byte", {24'b0, wd_a}, {24'b0, eb});
      end
    end
    if (done_a === 1'b1) begin
      if (da.size() == 0) begin
        total++; bad++;
        $display("FAIL a_extra_done: got done at cycle %0d, required none", cyc);
      end else begin
        ec = da.pop_front();
        chk("a_done_cycle", cyc, ec);
      end
    end
    if (wr_b === 1'b1) begin
      if (qb.size() == 0) begin
        total++; bad++;
        $display("FAIL b_extra_write: got write of %02h, required no write (cycle %0d)", wd_b, cyc);
      end else begin
        eb = qb.pop_front();
        chk("b_byte", {24'b0, wd_b}, {24'b0, eb});
      end
    end
    if (done_b === 1'b1) begin
      if (db.size() == 0) begin
        total++; bad++;
        $display("FAIL b_extra_done: got done at cycle %0d, required none", cyc);
      end else begin
        ec = db.pop_front();
        chk("b_done_cycle", cyc, ec);
      end
    end
  end

  // Runs one scenario on instance sel (0=a, 1=b). All offsets are labels
  // relative to the request edge t. Busy is expected inside either window.
  task automatic run(input int sel, input logic [NB_A*8-1:0] pay,
                     input int fl_lo, input int fl_hi,
                     input int req2_off, input logic [NB_A*8-1:0] pay2,
                     input int rst_off, input int done_off, input int done2_off,
                     input int b1lo, input int b1hi, input int b2lo, input int b2hi,
                     input int ncyc);
    int   t, c;
    logic bexp, s, f;
    @(posedge clock); #1;
    t = cyc + 1;
    if (sel == 0) begin
      if (done_off >= 0)  da.push_back(t + done_off);
      if (done2_off >= 0) da.push_back(t + done2_off);
      sig_a = 1'b1; data_a = pay;
    end else begin
      if (done_off >= 0)  db.push_back(t + done_off);
      if (done2_off >= 0) db.push_back(t + done2_off);
      sig_b = 1'b1; data_b = pay[NB_B*8-1:0];
    end
    for (int k = 0; k < ncyc; k++) begin
      @(negedge clock);
      c = cyc;
      bexp = ((c >= t + b1lo) && (c <= t + b1hi)) || ((c >= t + b2lo) && (c <= t + b2hi));
      chk(sel == 0 ? "a_busy" : "b_busy", {31'b0, (sel == 0) ? busy_a : busy_b}, {31'b0, bexp});
      @(posedge clock); #1;
      c = cyc;
      s = (req2_off >= 0) && (c == t + req2_off);
      f = (c >= t + fl_lo) && (c <= t + fl_hi);
      reset = (rst_off >= 0) && (c == t + rst_off);
      if (sel == 0) begin
        sig_a = s; full_a = f;
        if (s) data_a = pay2;
      end else begin
        sig_b = s; full_b = f;
        if (s) data_b = pay2[NB_B*8-1:0];
      end
    end
    sig_a = 1'b0; sig_b = 1'b0; full_a = 1'b0; full_b = 1'b0; reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("qa_missing_writes", qa.size(), 0);
    chk("qb_missing_writes", qb.size(), 0);
    chk("da_missing_done", da.size(), 0);
    chk("db_missing_done", db.size(), 0);
    qa.delete(); qb.delete(); da.delete(); db.delete();
  endtask

  logic [NB_A*8-1:0] pay_inc, pay_42, pay_alt, pay_x, pay_s1, pay_s2;

  initial begin
    for (int i = 0; i < NB_A; i++) begin
      pay_inc[8*i +: 8] = 8'(i);
      pay_42[8*i +: 8]  = 8'h42;
      pay_alt[8*i +: 8] = 8'(i) ^ 8'hA5;
      pay_x[8*i +: 8]   = 8'hE7;
    end
    pay_s1 = '0; pay_s1[31:0] = 32'hDDCCBBAA;
    pay_s2 = '0; pay_s2[31:0] = 32'h44332211;

    // Reset held with a request pending: nothing may be captured or written.
    reset = 1'b1; sig_a = 1'b1; sig_b = 1'b1; full_a = 1'b0; full_b = 1'b0;
    data_a = pay_x; data_b = 32'hFFFF_FFFF;
    repeat (3) begin
      @(negedge clock);
      chk("rst_wr_a", {31'b0, wr_a}, 0);
      chk("rst_busy_a", {31'b0, busy_a}, 0);
      chk("rst_done_a", {31'b0, done_a}, 0);
      chk("rst_wdata_a", {24'b0, wd_a}, 0);
      chk("rst_wr_b", {31'b0, wr_b}, 0);
      chk("rst_busy_b", {31'b0, busy_b}, 0);
      chk("rst_wdata_b", {24'b0, wd_b}, 0);
    end
    @(posedge clock); #1;
    reset = 1'b0; sig_a = 1'b0; sig_b = 1'b0;
    repeat (2) begin
      @(negedge clock);
      chk("post_rst_busy_a", {31'b0, busy_a}, 0);
      chk("post_rst_wr_a", {31'b0, wr_a}, 0);
    end

    // Incrementing frame, no backpressure: done at label t+220.
    for (int i = 0; i < NB_A; i++) qa.push_back(8'(i));
    run(0, pay_inc, -1, -2, -1, pay_inc, -1, 220, -1, 0, 219, -1, -2, 225);
    $display("test incrementing frame: checks=%0d bad=%0d", total, bad);

    // 0x42 frame, FIFO full for labels t+4..t+13: done at label t+230.
    for (int i = 0; i < NB_A; i++) qa.push_back(8'h42);
    run(0, pay_42, 4, 13, -1, pay_42, -1, 230, -1, 0, 229, -1, -2, 236);
    $display("test backpressure frame: checks=%0d bad=%0d", total, bad);

    // Second request sampled at edge t+50 while busy: ignored.
    for (int i = 0; i < NB_A; i++) qa.push_back(8'(i));
    run(0, pay_inc, -1, -2, 49, pay_x, -1, 220, -1, 0, 219, -1, -2, 230);
    $display("test request while busy: checks=%0d bad=%0d", total, bad);

    // Reset sampled at edge t+100: writes of bytes 0..98 only, no done.
    for (int i = 0; i < 99; i++) qa.push_back(8'(i) ^ 8'hA5);
    run(0, pay_alt, -1, -2, -1, pay_alt, 99, -1, -1, 0, 99, -1, -2, 130);
    $display("test reset mid-frame: checks=%0d bad=%0d", total, bad);

    // Fresh frame after the abort starts again from byte 0.
    for (int i = 0; i < NB_A; i++) qa.push_back(8'(i));
    run(0, pay_inc, -1, -2, -1, pay_inc, -1, 220, -1, 0, 219, -1, -2, 225);
    $display("test frame after abort: checks=%0d bad=%0d", total, bad);

    // 4-byte build, second request held during the done cycle.
    qb.push_back(8'hAA); qb.push_back(8'hBB); qb.push_back(8'hCC); qb.push_back(8'hDD);
    qb.push_back(8'h11); qb.push_back(8'h22); qb.push_back(8'h33); qb.push_back(8'h44);
    run(1, pay_s1, -1, -2, 4, pay_s2, -1, 4, 9, 0, 3, 5, 8, 14);
    $display("test small back-to-back: checks=%0d bad=%0d", total, bad);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
